// File: rtl/wb_sel_pipe.sv
// -----------------------------------------------------------------------------
// wb_sel_pipe
//
// Registered write-back selector for the pipelined / multi-cycle RISC-V core.
// Chooses the register-file write data from one of four sources (ALU result,
// PC+4, aligned/extended load data, extended immediate). It produces a
// registered write-back bus that carries a one-cycle valid strobe.
//
// Non-load instructions complete one cycle after acceptance, and a new one may
// be accepted every cycle. A load parks the block in WAIT_MEM until the data
// memory answers with dram_rvalid_i. If memory does not answer within TIMEOUT
// cycles, the load is aborted: a write-back strobe is issued with the write
// disabled, and the sticky err_o flag is raised.
//
// Parameters:
//   XLEN    - datapath width, 32 or 64 (loads use the low 32 bits of memory data)
//   RA_W    - register address width
//   TIMEOUT - WAIT_MEM cycles before a load is aborted (>= 1)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   in_valid_i     upstream instruction valid
//   in_ready_o     block can accept an instruction (high only in IDLE)
//   wd_sel_i       source select: 00 ALU, 01 PC+4, 10 load, 11 ext/imm
//   rf_we_i        instruction writes a register
//   rd_addr_i      destination register
//   funct3_i       load size/sign (LB/LH/LW/LBU/LHU)
//   byte_off_i     address[1:0] of the load
//   alu_c_i        ALU result
//   npc_pc4_i      PC+4
//   sext_ext_i     extended immediate
//   dram_rd_i      memory read data
//   dram_rvalid_i  memory read data valid (sampled only in WAIT_MEM)
//   wb_valid_o     one-cycle write-back strobe
//   wb_we_o        register write enable (never set for x0)
//   wb_addr_o      register address
//   wd_o           write data
//   err_o          sticky load-timeout flag
// -----------------------------------------------------------------------------
module wb_sel_pipe #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      wd_sel_i,
  input  logic            rf_we_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      byte_off_i,
  input  logic [XLEN-1:0] alu_c_i,
  input  logic [XLEN-1:0] npc_pc4_i,
  input  logic [XLEN-1:0] sext_ext_i,
  input  logic [XLEN-1:0] dram_rd_i,
  input  logic            dram_rvalid_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [RA_W-1:0] wb_addr_o,
  output logic [XLEN-1:0] wd_o,
  output logic            err_o
);

  // The counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_PC4  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_EXT  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  // Align and extend a loaded word. Bytes pick a lane with byte_off, and halves
  // pick a lane with byte_off[1] only. Unknown funct3 codes behave as LW, and
  // LW sign-extends when XLEN=64.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [31:0] word,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = XLEN'($signed(byte_v));
      F3_LBU:  res = XLEN'(byte_v);
      F3_LH:   res = XLEN'($signed(half_v));
      F3_LHU:  res = XLEN'(half_v);
      default: res = XLEN'($signed(word));
    endcase
    return res;
  endfunction

  // Non-load source multiplexer. The load code never reaches this path, so it
  // returns zero.
  function automatic logic [XLEN-1:0] select_src(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] ext
  );
    logic [XLEN-1:0] res;
    case (sel)
      SEL_ALU: res = alu;
      SEL_PC4: res = pc4;
      SEL_EXT: res = ext;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load context captured at acceptance
  logic [RA_W-1:0] ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;

  // Registered write-back bus
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [RA_W-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic            accept_s;

  assign in_ready_o = (state_q == IDLE);
  assign accept_s   = in_valid_i && in_ready_o;

  assign wb_valid_o = wb_valid_q;
  assign wb_we_o    = wb_we_q;
  assign wb_addr_o  = wb_addr_q;
  assign wd_o       = wd_q;
  assign err_o      = err_q;

  // Next-state logic for the FSM, timeout counter, load context and write-back bus
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_addr_d  = wb_addr_q;
    wd_d       = wd_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (accept_s && (wd_sel_i == SEL_LOAD)) begin
          ld_rd_d  = rd_addr_i;
          ld_we_d  = rf_we_i;
          ld_f3_d  = funct3_i;
          ld_off_d = byte_off_i;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = WAIT_MEM;
        end else if (accept_s) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = rd_addr_i;
          wb_we_d    = rf_we_i && (rd_addr_i != {RA_W{1'b0}});
          wd_d       = select_src(wd_sel_i, alu_c_i, npc_pc4_i, sext_ext_i);
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_MEM: begin
        // rvalid is checked first, so a response in the final allowed cycle
        // takes priority over the timeout.
        if (dram_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = ld_rd_q;
          wb_we_d    = ld_we_q && (ld_rd_q != {RA_W{1'b0}});
          wd_d       = extract_load(dram_rd_i[31:0], ld_f3_q, ld_off_q);
          cnt_d      = {CNT_W{1'b0}};
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = ld_rd_q;
          wb_we_d    = 1'b0;
          wd_d       = {XLEN{1'b0}};
          err_d      = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      ld_rd_q    <= {RA_W{1'b0}};
      ld_we_q    <= 1'b0;
      ld_f3_q    <= 3'b000;
      ld_off_q   <= 2'b00;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= {RA_W{1'b0}};
      wd_q       <= {XLEN{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_sel_pipe.sv
module tb_wb_sel_pipe;

  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [1:0]      wd_sel_i;
  logic            rf_we_i;
  logic [RA_W-1:0] rd_addr_i;
  logic [2:0]      funct3_i;
  logic [1:0]      byte_off_i;
  logic [XLEN-1:0] alu_c_i;
  logic [XLEN-1:0] npc_pc4_i;
  logic [XLEN-1:0] sext_ext_i;
  logic [XLEN-1:0] dram_rd_i;
  logic            dram_rvalid_i;
  logic            wb_valid_o;
  logic            wb_we_o;
  logic [RA_W-1:0] wb_addr_o;
  logic [XLEN-1:0] wd_o;
  logic            err_o;

  wb_sel_pipe #(.XLEN(XLEN), .RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .wd_sel_i     (wd_sel_i),
    .rf_we_i      (rf_we_i),
    .rd_addr_i    (rd_addr_i),
    .funct3_i     (funct3_i),
    .byte_off_i   (byte_off_i),
    .alu_c_i      (alu_c_i),
    .npc_pc4_i    (npc_pc4_i),
    .sext_ext_i   (sext_ext_i),
    .dram_rd_i    (dram_rd_i),
    .dram_rvalid_i(dram_rvalid_i),
    .wb_valid_o   (wb_valid_o),
    .wb_we_o      (wb_we_o),
    .wb_addr_o    (wb_addr_o),
    .wd_o         (wd_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            we;
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
    logic            err;
    int              at;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic we, input logic [RA_W-1:0] addr,
                      input logic [XLEN-1:0] data, input logic err, input int at);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.err = err; e.at = at;
    sb.push_back(e);
  endtask

  // Monitor: every write-back strobe must match the oldest expected entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb: pulse at cycle %0d we=%b addr=%0d data=%h err=%b",
                   cyc, wb_we_o, wb_addr_o, wd_o, err_o);
        end else begin
          e = sb.pop_front();
          if (wb_we_o !== e.we || wb_addr_o !== e.addr || wd_o !== e.data ||
              err_o !== e.err || cyc != e.at) begin
            errors++;
            $display("FAIL wb_pulse: got we=%b addr=%0d data=%h err=%b cycle=%0d expected we=%b addr=%0d data=%h err=%b cycle=%0d",
                     wb_we_o, wb_addr_o, wd_o, err_o, cyc, e.we, e.addr, e.data, e.err, e.at);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] sel, input logic we, input logic [RA_W-1:0] rd,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4,
                       input logic [XLEN-1:0] ext);
    check("in_ready_idle", {63'd0, in_ready_o}, 64'd1);
    wd_sel_i = sel; rf_we_i = we; rd_addr_i = rd; funct3_i = f3; byte_off_i = off;
    alu_c_i = alu; npc_pc4_i = pc4; sext_ext_i = ext;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Non-load op: the result appears one cycle after acceptance
  task automatic op(input logic [1:0] sel, input logic we, input logic [RA_W-1:0] rd,
                    input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4,
                    input logic [XLEN-1:0] ext, input logic [XLEN-1:0] exp_data,
                    input logic exp_we, input logic exp_err);
    push(exp_we, rd, exp_data, exp_err, cyc + 1);
    issue(sel, we, rd, 3'b000, 2'b00, alu, pc4, ext);
  endtask

  // Load that waits wait_n cycles in WAIT_MEM before the memory responds
  task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [RA_W-1:0] rd,
                      input logic we, input int wait_n, input logic [XLEN-1:0] data,
                      input logic [XLEN-1:0] exp_data, input logic exp_we, input logic exp_err);
    issue(2'b10, we, rd, f3, off, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < wait_n; i++) begin
      check("in_ready_wait", {63'd0, in_ready_o}, 64'd0);
      @(posedge clk); #1;
    end
    dram_rd_i = data;
    dram_rvalid_i = 1'b1;
    push(exp_we, rd, exp_data, exp_err, cyc + 1);
    @(posedge clk); #1;
    dram_rvalid_i = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready_o}, 64'd1);
    check({tag, "_valid"}, {63'd0, wb_valid_o}, 64'd0);
    check({tag, "_we"},    {63'd0, wb_we_o}, 64'd0);
    check({tag, "_addr"},  {59'd0, wb_addr_o}, 64'd0);
    check({tag, "_wd"},    {32'd0, wd_o}, 64'd0);
    check({tag, "_err"},   {63'd0, err_o}, 64'd0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; in_valid_i = 1'b0; wd_sel_i = 2'b00; rf_we_i = 1'b0;
    rd_addr_i = '0; funct3_i = 3'b000; byte_off_i = 2'b00;
    alu_c_i = '0; npc_pc4_i = '0; sext_ext_i = '0; dram_rd_i = '0; dram_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_quiet("reset");

    // Back-to-back non-load ops
    op(2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b0);
    op(2'b01, 1'b1, 5'd1, 32'h0, 32'h0000_0104, 32'h0, 32'h0000_0104, 1'b1, 1'b0);

    // Loads: sign/zero extension and lane selection
    load(3'b000, 2'd3, 5'd7, 1'b1, 3, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1, 1'b0);
    load(3'b101, 2'd2, 5'd8, 1'b1, 0, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1, 1'b0);
    load(3'b001, 2'd1, 5'd9, 1'b1, 1, 32'h1234_8001, 32'hFFFF_8001, 1'b1, 1'b0);
    load(3'b010, 2'd0, 5'd10, 1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    load(3'b100, 2'd1, 5'd11, 1'b1, 1, 32'h0000_A500, 32'h0000_00A5, 1'b1, 1'b0);
    load(3'b111, 2'd3, 5'd12, 1'b1, 0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 1'b0);
    load(3'b010, 2'd0, 5'd0, 1'b1, 0, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 1'b0);

    // x0 write is suppressed; rf_we=0 is honoured
    op(2'b11, 1'b1, 5'd0, 32'h0, 32'h0, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1'b0);
    op(2'b00, 1'b0, 5'd3, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 1'b0);

    // rvalid in the last allowed cycle wins over the timeout
    load(3'b010, 2'd0, 5'd13, 1'b1, TIMEOUT - 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, 1'b0);
    check("no_err_after_late_rvalid", {63'd0, err_o}, 64'd0);

    // Load timeout
    issue(2'b10, 1'b1, 5'd14, 3'b010, 2'd0, 32'h0, 32'h0, 32'h0);
    t0 = cyc;
    push(1'b0, 5'd14, 32'h0, 1'b1, t0 + TIMEOUT);
    for (int i = 0; i < TIMEOUT; i++) begin
      check("in_ready_timeout_wait", {63'd0, in_ready_o}, 64'd0);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", {63'd0, err_o}, 64'd1);
    op(2'b00, 1'b1, 5'd4, 32'h0000_0042, 32'h0, 32'h0, 32'h0000_0042, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("err_still_sticky", {63'd0, err_o}, 64'd1);

    // Reset in the middle of a load, then a stray rvalid in IDLE
    issue(2'b10, 1'b1, 5'd15, 3'b010, 2'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("in_ready_before_reset", {63'd0, in_ready_o}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_quiet("midload_reset");
    dram_rd_i = 32'hFFFF_FFFF;
    dram_rvalid_i = 1'b1;
    @(posedge clk); #1;
    dram_rvalid_i = 1'b0;
    @(posedge clk); #1;
    check_quiet("stray_rvalid");

    // Normal operation resumes with the error flag cleared
    op(2'b00, 1'b1, 5'd6, 32'h0000_0077, 32'h0, 32'h0, 32'h0000_0077, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_sel_pipe.md
Name: wb_sel_pipe

Overview:
- Registered, parametrised write-back selector for the multi-cycle/pipelined RISC-V core.
- Selects the register-file write data from one of four sources:
  - ALU result
  - PC+4
  - load data, aligned and extended for LB/LH/LW/LBU/LHU
  - immediate/extended value
- Handles variable-latency data-memory responses with a valid/ready handshake and a load timeout.
- Produces a registered write-back bus (we/addr/data/valid) to the register file.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- RA_W, 5, register address width.
- TIMEOUT, 15, maximum cycles spent in WAIT_MEM before a load is aborted; must be ≥ 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  upstream instruction valid
- in_ready_o  out  1  block can accept an instruction (combinational, = state IDLE)
- wd_sel_i  in  2  source select: 00 ALU, 01 PC+4, 10 load, 11 ext/imm
- rf_we_i  in  1  instruction writes a register
- rd_addr_i  in  RA_W  destination register
- funct3_i  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- byte_off_i  in  2  address[1:0] of the load
- alu_c_i  in  XLEN  ALU result
- npc_pc4_i  in  XLEN  PC+4
- sext_ext_i  in  XLEN  extended immediate
- dram_rd_i  in  XLEN  memory read data
- dram_rvalid_i  in  1  memory read data valid
- wb_valid_o  out  1  one-cycle write-back strobe
- wb_we_o  out  1  register write enable
- wb_addr_o  out  RA_W  register address
- wd_o  out  XLEN  write data
- err_o  out  1  sticky load-timeout flag

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, wait counter=0.
  - wb_valid_o=0, wb_we_o=0, wb_addr_o=0, wd_o=0, err_o=0.
  - Reset while in WAIT_MEM discards the pending load; no write-back is produced.
- FSM states: IDLE, WAIT_MEM.
- Accept: handshake occurs when in_valid_i && in_ready_o.
- IDLE accept, wd_sel_i ≠ 10 (non-load):
  - Next edge: wd_o = selected source, wb_addr_o = rd_addr_i, wb_we_o = rf_we_i && (rd_addr_i≠0), wb_valid_o=1 for exactly one cycle.
  - Latency is 1 cycle; back-to-back acceptance every cycle is allowed.
- IDLE accept, wd_sel_i = 10 (load):
  - Latch rd_addr_i, rf_we_i, funct3_i, byte_off_i.
  - Go to WAIT_MEM with counter=0; wb_valid_o stays 0.
- WAIT_MEM:
  - in_ready_o=0.
  - dram_rvalid_i is sampled only in this state; in IDLE it is ignored. Minimum load latency is therefore 2 cycles from accept to wb_valid_o.
  - On dram_rvalid_i=1: next edge drives wd_o = extracted data, wb_addr_o / wb_we_o from the latched values (x0 suppressed), wb_valid_o=1, state=IDLE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 and still no rvalid: next edge drives wb_valid_o=1, wb_we_o=0, wd_o=0, err_o=1, state=IDLE.
  - If rvalid arrives in the same cycle the timeout would fire, rvalid wins.
- Load extraction (lane = byte_off for bytes, byte_off[1] for halves; XLEN=64 uses the low 32 bits of dram_rd_i):
  - LB: sign-extend byte[lane] to XLEN.
  - LBU: zero-extend byte[lane].
  - LH: sign-extend half[byte_off[1]]; byte_off[0] is ignored.
  - LHU: zero-extend half[byte_off[1]].
  - LW: word, sign-extended to XLEN when XLEN=64.
  - Any other funct3: LW behaviour.
- err_o is sticky until reset.
- Outputs hold their last value when wb_valid_o=0, except wb_valid_o itself, which is a one-cycle pulse.

Test Plan:
- Non-load, back-to-back:
  - Stimulus: ALU op, alu_c_i=0x0000_1234, rd=5, rf_we=1; next cycle sel=01, pc4=0x0000_0104, rd=1.
  - Required: wb_valid_o high two consecutive cycles; wd_o=0x1234 then 0x104; addr 5 then 1.
- Signed byte load:
  - Stimulus: LB, off=3, rvalid after 3 cycles with dram_rd_i=0x80FF_0000.
  - Required: in_ready_o low while waiting; wd_o=0xFFFF_FF80, single wb_valid_o pulse.
- Unsigned half load:
  - Stimulus: LHU, off=2, dram_rd_i=0xBEEF_1234.
  - Required: wd_o=0x0000_BEEF.
- Write to x0:
  - Stimulus: rd=0 with rf_we=1, sel=11, sext=0xABCD_0000.
  - Required: wb_valid_o=1, wb_we_o=0.
- Load timeout:
  - Stimulus: load issued, no rvalid for TIMEOUT cycles.
  - Required: wb_valid_o=1, wb_we_o=0, wd_o=0, err_o=1 held; a subsequent ALU op completes normally.
- Reset mid-load and stray rvalid:
  - Stimulus: rst_n=0 during WAIT_MEM; then a stray rvalid while in IDLE.
  - Required: no write-back pulse; state IDLE; in_ready_o=1; all outputs 0.
